// File: rtl/flac_pkg.sv
// Shared widths, constants and helpers for the FLAC residual path.
package flac_pkg;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned MSB_W  = 16;
    localparam int unsigned LSB_W  = 16;
    localparam int unsigned RICE_W = 4;
    localparam int unsigned CNT_W  = 16;

    localparam logic [RICE_W-1:0] RICE_ESCAPE = 4'hF;

    // Zigzag decode: even u -> u/2, odd u -> -(u+1)/2.
    function automatic logic signed [RES_W-1:0] unzigzag(input logic [RES_W-1:0] u);
        return signed'((u >> 1) ^ {RES_W{u[0]}});
    endfunction
endpackage

// File: rtl/residual_assembler_if.sv
// Decoder-strobe input and valid/ready residual output of the residual assembler.
interface residual_assembler_if;
    import flac_pkg::*;

    logic                    iDone;
    logic [MSB_W-1:0]        iMSB;
    logic [LSB_W-1:0]        iLSB;
    logic [RICE_W-1:0]       iRiceParam;
    logic signed [RES_W-1:0] oResidual;
    logic                    oValid;
    logic                    iReady;

    modport master (output iDone, iMSB, iLSB, iRiceParam, iReady,
                    input  oResidual, oValid);
    modport slave  (input  iDone, iMSB, iLSB, iRiceParam, iReady,
                    output oResidual, oValid);
endinterface

// File: rtl/residual_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only if a pop frees a slot.
module residual_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en_c, rd_en_c;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en_c = pop && !empty;
    assign wr_en_c = push && (!full || rd_en_c);
    assign dout    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en_c) rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge iClk) begin
        if (wr_en_c) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/residual_assembler.sv
// Folds Rice (MSB, LSB, k) triples, un-zigzags them into signed residuals and buffers them,
// tracking the per-subframe residual count and sticky overflow/escape flags.
module residual_assembler #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned RES_W = 32
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [15:0]                iBlockSize,
    input  logic [3:0]                 iPredictorOrder,
    residual_assembler_if.slave        bus,
    output logic [15:0]                oCount,
    output logic                       oFrameDone,
    output logic                       oOverflow,
    output logic                       oEscape
);
    import flac_pkg::*;

    logic [CNT_W-1:0] expected_q, expected_d, count_q, count_d;
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [RES_W-1:0] u_q, u_d, r_q, r_d;
    logic             overflow_q, overflow_d, escape_q, escape_d;

    logic             at_limit_c, accept_c, pop_c, drop_c;
    logic             fifo_full, fifo_empty;
    logic [RES_W-1:0] mask_c, fold_c, fifo_dout;

    assign at_limit_c = (count_q == expected_q);
    assign accept_c   = bus.iDone && !at_limit_c;
    assign pop_c      = !fifo_empty && bus.iReady;
    assign drop_c     = s2_valid_q && fifo_full && !pop_c;

    // Only the low k bits of the remainder take part in the fold.
    assign mask_c = (RES_W'(1) << bus.iRiceParam) - RES_W'(1);
    assign fold_c = (RES_W'(bus.iMSB) << bus.iRiceParam) | (RES_W'(bus.iLSB) & mask_c);

    always_comb begin
        expected_d = expected_q;
        count_d    = count_q;
        s1_valid_d = accept_c;
        s2_valid_d = s1_valid_q;
        u_d        = u_q;
        r_d        = r_q;
        overflow_d = overflow_q;
        escape_d   = escape_q;
        if (accept_c) begin
            u_d     = fold_c;
            count_d = count_q + CNT_W'(1);
            if (bus.iRiceParam == RICE_ESCAPE) escape_d = 1'b1;
        end
        if (bus.iDone && at_limit_c) overflow_d = 1'b1;
        if (s1_valid_q) r_d = RES_W'(unzigzag(u_q));
        if (drop_c) overflow_d = 1'b1;
    end

    // Reset also captures the residual budget for the coming subframe.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            expected_q <= iBlockSize - CNT_W'(iPredictorOrder);
            count_q    <= '0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            u_q        <= '0;
            r_q        <= '0;
            overflow_q <= 1'b0;
            escape_q   <= 1'b0;
        end else begin
            expected_q <= expected_d;
            count_q    <= count_d;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            u_q        <= u_d;
            r_q        <= r_d;
            overflow_q <= overflow_d;
            escape_q   <= escape_d;
        end
    end

    residual_fifo #(.DEPTH(DEPTH), .WIDTH(RES_W)) u_fifo (
        .iClk  (iClk),
        .iRst  (iRst),
        .push  (s2_valid_q),
        .pop   (pop_c),
        .din   (r_q),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.oResidual = signed'(fifo_dout);
    assign bus.oValid    = !fifo_empty;
    assign oCount        = count_q;
    assign oOverflow     = overflow_q;
    assign oEscape       = escape_q;
    assign oFrameDone    = at_limit_c && fifo_empty && !s1_valid_q && !s2_valid_q;
endmodule

// File: tb/tb_residual_assembler.sv
// Randomized self-checking bench for residual_assembler against a queue-based reference model.
module tb_residual_assembler;
    import flac_pkg::*;

    localparam int DEPTH = 8;

    logic        iClk = 1'b0;
    logic        iRst;
    logic [15:0] iBlockSize;
    logic [3:0]  iPredictorOrder;
    logic [15:0] oCount;
    logic        oFrameDone, oOverflow, oEscape;

    residual_assembler_if bus();

    residual_assembler #(.DEPTH(DEPTH), .RES_W(32)) dut (
        .iClk            (iClk),
        .iRst            (iRst),
        .iBlockSize      (iBlockSize),
        .iPredictorOrder (iPredictorOrder),
        .bus             (bus),
        .oCount          (oCount),
        .oFrameDone      (oFrameDone),
        .oOverflow       (oOverflow),
        .oEscape         (oEscape)
    );

    always #5 iClk = ~iClk;

    typedef struct { logic signed [31:0] val; int due; } flight_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [31:0] m_fifo[$];
    flight_t            m_pipe[$];
    logic [15:0]        m_count, m_expected;
    logic               m_ovf, m_esc;

    // Folded value from plain arithmetic, then zigzag-decoded by parity.
    function automatic logic signed [31:0] ref_res(input logic [15:0] msb, input logic [15:0] lsb,
                                                   input logic [3:0] k);
        longint u;
        u = longint'(msb) * (longint'(1) << k) + (longint'(lsb) % (longint'(1) << k));
        if (u % 2 == 0) return 32'(u / 2);
        return 32'(-((u + 1) / 2));
    endfunction

    function automatic logic model_done();
        return (m_count == m_expected) && (m_fifo.size() == 0) && (m_pipe.size() == 0);
    endfunction

    task automatic set_in(input logic done, input logic [15:0] msb, input logic [15:0] lsb,
                          input logic [3:0] k, input logic ready);
        bus.iDone      = done;
        bus.iMSB       = msb;
        bus.iLSB       = lsb;
        bus.iRiceParam = k;
        bus.iReady     = ready;
    endtask

    task automatic rand_strobe(input logic ready);
        set_in(1'b1, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 14)), ready);
    endtask

    // Advance one clock edge and apply the same edge to the reference model.
    task automatic tick();
        @(posedge iClk);
        if (iRst) begin
            m_fifo.delete();
            m_pipe.delete();
            m_count    = '0;
            m_ovf      = 1'b0;
            m_esc      = 1'b0;
            m_expected = 16'(iBlockSize - 16'(iPredictorOrder));
        end else begin
            if (m_fifo.size() > 0 && bus.iReady) void'(m_fifo.pop_front());
            if (m_pipe.size() > 0 && m_pipe[0].due == cyc) begin
                if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pipe[0].val);
                else m_ovf = 1'b1;
                void'(m_pipe.pop_front());
            end
            if (bus.iDone) begin
                if (m_count == m_expected) m_ovf = 1'b1;
                else begin
                    m_count = m_count + 16'd1;
                    if (bus.iRiceParam == 4'hF) m_esc = 1'b1;
                    m_pipe.push_back('{ref_res(bus.iMSB, bus.iLSB, bus.iRiceParam), cyc + 2});
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic [15:0] bs, input logic [3:0] ord);
        iRst = 1'b1; iBlockSize = bs; iPredictorOrder = ord;
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b0);
        tick();
        iRst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(16'd16, 4'd2);
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.oValid); end
        checks++; if (oCount !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", oCount); end
        checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", oOverflow); end
        checks++; if (oEscape !== 1'b0) begin errors++; $display("FAIL reset_escape got=%b exp=0", oEscape); end
        checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone got=%b exp=0", oFrameDone); end
    endtask

    task automatic test_single();
        set_in(1'b1, 16'd3, 16'd1, 4'd2, 1'b0);
        tick();
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b0);
        tick();
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL single_early_valid got=%b exp=0", bus.oValid); end
        tick();
        checks++; if (bus.oValid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.oValid); end
        checks++; if (bus.oResidual !== -32'sd7) begin errors++; $display("FAIL single_residual got=%0d exp=-7", bus.oResidual); end
        checks++; if (oCount !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", oCount); end
        bus.iReady = 1'b1;
        tick();
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL single_pop got=%b exp=0", bus.oValid); end
    endtask

    task automatic test_sequence();
        logic signed [31:0] want [3];
        logic signed [31:0] got[$];
        int                 first_cyc;
        int                 last_cyc;
        want[0] = 32'sd6; want[1] = -32'sd1; want[2] = 32'sd0;
        first_cyc = -1; last_cyc = -1;
        set_in(1'b1, 16'd3, 16'd0, 4'd2, 1'b1); tick();
        set_in(1'b1, 16'd1, 16'd0, 4'd0, 1'b1); tick();
        set_in(1'b1, 16'd0, 16'd0, 4'd0, 1'b1); tick();
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (bus.oValid === 1'b1) begin
                got.push_back(bus.oResidual);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            tick();
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL seq_len got=%0d exp=3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== want[i]) begin errors++; $display("FAIL seq_val[%0d] got=%0d exp=%0d", i, got[i], want[i]); end
            end
        end
        checks++; if (last_cyc - first_cyc != 2) begin errors++; $display("FAIL seq_rate got=%0d exp=2", last_cyc - first_cyc); end
    endtask

    task automatic test_wide();
        logic signed [31:0] got[$];
        set_in(1'b1, 16'hFFFF, 16'h3FFF, 4'd14, 1'b1); tick();
        set_in(1'b1, 16'h0000, 16'hFFFF, 4'd3, 1'b1); tick();
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (bus.oValid === 1'b1) got.push_back(bus.oResidual);
            tick();
        end
        checks++; if (got.size() != 2) begin errors++; $display("FAIL wide_len got=%0d exp=2", got.size()); end
        if (got.size() == 2) begin
            checks++; if (got[0] !== 32'shE0000000) begin errors++; $display("FAIL wide_k14 got=%h exp=e0000000", got[0]); end
            checks++; if (got[1] !== -32'sd4) begin errors++; $display("FAIL wide_lsb_mask got=%0d exp=-4", got[1]); end
        end
    endtask

    task automatic test_overflow();
        do_reset(16'd64, 4'd4);
        for (int i = 0; i < 9; i++) begin rand_strobe(1'b0); tick(); end
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (oOverflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", oOverflow); end
        checks++; if (oCount !== 16'd9) begin errors++; $display("FAIL ovf_count got=%0d exp=9", oCount); end
        checks++; if (bus.oResidual !== m_fifo[0]) begin errors++; $display("FAIL ovf_head got=%0d exp=%0d", bus.oResidual, m_fifo[0]); end
        // Strobe timed so its FIFO write lands on the same edge as a pop.
        rand_strobe(1'b0); tick();
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b0); tick();
        bus.iReady = 1'b1; tick();
        bus.iReady = 1'b0;
        checks++; if (oCount !== 16'd10) begin errors++; $display("FAIL ovf_full_pop_count got=%0d exp=10", oCount); end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus.oValid !== 1'b1 || m_fifo.size() == 0 || bus.oResidual !== m_fifo[0])
                begin errors++; $display("FAIL ovf_drain[%0d] valid=%b got=%0d", i, bus.oValid, bus.oResidual); end
            bus.iReady = 1'b1; tick();
        end
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", bus.oValid); end
    endtask

    task automatic test_limit();
        do_reset(16'd16, 4'd2);
        for (int i = 0; i < 14; i++) begin
            rand_strobe(1'b1);
            if (i == 5) bus.iRiceParam = 4'hF;
            tick();
        end
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b1);
        checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL limit_early_done got=%b exp=0", oFrameDone); end
        checks++; if (oOverflow !== 1'b0) begin errors++; $display("FAIL limit_no_ovf got=%b exp=0", oOverflow); end
        rand_strobe(1'b1); tick();
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b1);
        checks++; if (oCount !== 16'd14) begin errors++; $display("FAIL limit_count got=%0d exp=14", oCount); end
        checks++; if (oOverflow !== 1'b1) begin errors++; $display("FAIL limit_ovf got=%b exp=1", oOverflow); end
        checks++; if (oEscape !== 1'b1) begin errors++; $display("FAIL limit_escape got=%b exp=1", oEscape); end
        for (int i = 0; i < 6; i++) begin
            if (m_fifo.size() > 0) begin
                checks++;
                if (bus.oResidual !== m_fifo[0]) begin errors++; $display("FAIL limit_val got=%0d exp=%0d", bus.oResidual, m_fifo[0]); end
            end
            tick();
        end
        checks++; if (oFrameDone !== 1'b1) begin errors++; $display("FAIL limit_done got=%b exp=1", oFrameDone); end
    endtask

    task automatic test_midreset();
        do_reset(16'd40, 4'd8);
        for (int i = 0; i < 4; i++) begin
            rand_strobe(1'b0);
            if (i == 1) bus.iRiceParam = 4'hF;
            tick();
        end
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b0);
        tick();
        checks++; if (bus.oValid !== 1'b1 || oEscape !== 1'b1) begin errors++; $display("FAIL mid_pre valid=%b escape=%b exp=1,1", bus.oValid, oEscape); end
        do_reset(16'd20, 4'd5);
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", bus.oValid); end
        checks++; if (oCount !== 16'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", oCount); end
        checks++; if (oEscape !== 1'b0 || oOverflow !== 1'b0) begin errors++; $display("FAIL mid_flags esc=%b ovf=%b exp=0,0", oEscape, oOverflow); end
        for (int i = 0; i < 3; i++) tick();
        checks++; if (bus.oValid !== 1'b0) begin errors++; $display("FAIL mid_inflight got=%b exp=0", bus.oValid); end
        for (int i = 0; i < 15; i++) begin rand_strobe(1'b1); tick(); end
        set_in(1'b0, 16'd0, 16'd0, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (oCount !== 16'd15) begin errors++; $display("FAIL mid_new_count got=%0d exp=15", oCount); end
        checks++; if (oFrameDone !== 1'b1) begin errors++; $display("FAIL mid_new_done got=%b exp=1", oFrameDone); end
    endtask

    task automatic test_back_to_back();
        do_reset(16'($urandom_range(60, 200)), 4'($urandom_range(0, 15)));
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            tick();
            checks++;
            if (bus.oValid !== (m_fifo.size() > 0)) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%b", cyc, bus.oValid); end
            if (m_fifo.size() > 0) begin
                checks++;
                if (bus.oResidual !== m_fifo[0]) begin errors++; $display("FAIL b2b_res cyc=%0d got=%0d exp=%0d", cyc, bus.oResidual, m_fifo[0]); end
            end
            checks++;
            if (oCount !== m_count || oOverflow !== m_ovf || oEscape !== m_esc || oFrameDone !== model_done())
                begin errors++; $display("FAIL b2b_status cyc=%0d cnt=%0d/%0d ovf=%b/%b esc=%b/%b done=%b/%b", cyc,
                    oCount, m_count, oOverflow, m_ovf, oEscape, m_esc, oFrameDone, model_done()); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_wide();
        test_overflow();
        test_limit();
        test_midreset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/residual_assembler.md
Name: residual_assembler

Overview:
- Sits directly downstream of the Rice decoder and upstream of the LPC/fixed predictor reconstruction stage.
- Takes each decoded (MSB quotient, LSB remainder, Rice parameter) triple strobed by the decoder's done pulse and forms the folded value u = (MSB << k) | LSB.
- Un-zigzags u into a signed 32-bit residual and buffers it in a small FIFO with valid/ready output.
- Counts residuals per subframe and flags completion, overflow and escape-code errors.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >= 4).
- RES_W, 32, residual width in bits.

Ports:
- iClk  in  1  clock
- iRst  in  1  reset, synchronous, active-high; also latches subframe configuration
- iBlockSize  in  16  frame block size, sampled on iRst
- iPredictorOrder  in  4  predictor order, sampled on iRst
- iDone  in  1  one-cycle strobe from Rice decoder; iMSB/iLSB/iRiceParam valid this cycle
- iMSB  in  16  unary quotient
- iLSB  in  16  binary remainder (only low k bits meaningful)
- iRiceParam  in  4  Rice parameter k
- oResidual  out  RES_W  signed residual at FIFO head (show-ahead)
- oValid  out  1  FIFO non-empty
- iReady  in  1  consumer accepts oResidual when oValid && iReady
- oCount  out  16  residuals accepted into the pipeline this subframe
- oFrameDone  out  1  level: all expected residuals accepted and FIFO drained
- oOverflow  out  1  sticky: a residual was dropped
- oEscape  out  1  sticky: iRiceParam == 4'hF seen on an accepted strobe

Behaviour:
- Reset (iRst high at a clock edge):
  - All outputs are 0; FIFO is emptied; pipeline valid bits are cleared.
  - expected = iBlockSize - iPredictorOrder (16-bit, wraps if order > size; no check).
  - Reset mid-operation discards everything in flight.
- Stage 1, on iDone && (oCount != expected):
  - Register u = ({16'b0, iMSB} << k) | ({16'b0, iLSB} & ((1<<k)-1)), all 32-bit.
  - oCount increments by 1.
  - If k == 4'hF, set oEscape; the value is still processed.
- iDone when oCount == expected: strobe ignored, oOverflow set, oCount holds.
- Stage 2: residual r = (u >> 1) ^ -(u & 1), i.e. even u gives u/2 and odd u gives -(u+1)/2. Registered, then written to the FIFO.
- Latency: iDone at edge N gives FIFO write at N+2; oValid rises after edge N+2 when the FIFO was empty; back-to-back strobes sustain 1 residual/cycle.
- FIFO:
  - Pop when oValid && iReady; oResidual shows the head entry combinationally from the registered memory.
  - Write when full with no pop that cycle: entry dropped, oOverflow set. Write when full with a pop the same cycle: write accepted.
  - Simultaneous push/pop when empty: push only; oValid rises the next cycle.
  - Pointers are log2(DEPTH)+1 bits; wrap-around is natural.
- The upstream decoder has no backpressure. Stages 1 and 2 never stall; only the FIFO can drop.
- oFrameDone = (oCount == expected) && FIFO empty && no pipeline stage valid. It stays high until iRst.
- Sticky flags clear only on iRst.

Decomposition:
- Shared package flac_pkg:
  - RES_W = 32, MSB_W = 16, LSB_W = 16, RICE_W = 4.
  - RICE_ESCAPE = 4'hF.
  - zigzag-decode function (unsigned 32 to signed 32).
- One sub-module residual_fifo: synchronous FIFO, parameters DEPTH/WIDTH; ports push, pop, din, dout, full, empty.
- Folding, unzigzag, counters and flags live in the top.

Test Plan:
- Rst with block 16, order 2 (expected 14); one strobe k=2, MSB=3, LSB=1: oResidual = -7 (u=13), oValid rises 2 edges after iDone, oCount=1.
- Strobes k=2 MSB=3 LSB=0; k=0 MSB=1; k=0 MSB=0 with iReady=1: outputs 6, -1, 0 in order, one per cycle.
- k=14, MSB=16'hFFFF, LSB=16'h3FFF: u=0x3FFFFFFF, so oResidual = 32'hE0000000. k=3 with LSB=16'hFFFF: upper LSB bits are masked off.
- DEPTH=8, iReady=0, 9 strobes: 8 stored, oOverflow=1, oCount=9. Then one strobe on a cycle where the FIFO is full and iReady=1: accepted, no extra overflow.
- Expected=14, 14 strobes then a 15th: 15th ignored, oOverflow=1, oCount=14. After draining, oFrameDone=1. A strobe with k=4'hF sets oEscape.
- iRst asserted with 3 entries buffered and 1 in flight: next cycle oValid=0, oCount=0, flags 0, and the new expected value is taken.
